// File: rtl/traffic_countdown_if.sv
// traffic_countdown_if: lamp/tick inputs and display outputs of one approach's
// countdown display.
//   master: drives tick and lamps (controller side), observes the display.
//   slave : the display block; consumes lamps/tick, drives phase, count,
//           bcd_tens, bcd_ones, seg, dig_sel and fault.
interface traffic_countdown_if;
   logic       tick;
   logic       red;
   logic       yellow;
   logic       green_left;
   logic       green_straight;
   logic [2:0] phase;
   logic [7:0] count;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic [6:0] seg;
   logic [1:0] dig_sel;
   logic       fault;

   modport master (
      output tick, red, yellow, green_left, green_straight,
      input  phase, count, bcd_tens, bcd_ones, seg, dig_sel, fault
   );

   modport slave (
      input  tick, red, yellow, green_left, green_straight,
      output phase, count, bcd_tens, bcd_ones, seg, dig_sel, fault
   );
endinterface

// File: rtl/traffic_countdown.sv
// traffic_countdown: per-approach phase countdown display.
// Decodes the four lamps into a phase, loads that phase's duration on every
// phase change, counts down on tick (saturating at 0), and drives a
// two-digit multiplexed 7-segment display. Invalid lamp patterns give FAULT.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - traffic_countdown_if.slave: tick, lamps in; phase, count,
//          bcd_tens, bcd_ones, seg {g..a}, dig_sel (01 ones / 10 tens), fault out
module traffic_countdown #(
   parameter int unsigned T_LEFT     = 20,
   parameter int unsigned T_STRAIGHT = 40,
   parameter int unsigned T_YELLOW   = 10,
   parameter int unsigned T_RED      = 70,
   parameter int unsigned SCAN_DIV   = 1000
) (
   input logic                clk,
   input logic                rst,
   traffic_countdown_if.slave bus
);

   localparam int unsigned ScanW = $clog2(SCAN_DIV);

   typedef enum logic [2:0] {
      PhIdle     = 3'd0,
      PhRed      = 3'd1,
      PhYellow   = 3'd2,
      PhLeft     = 3'd3,
      PhStraight = 3'd4,
      PhFault    = 3'd7
   } phase_e;

   phase_e           phase_q, phase_d, phase_dec;
   logic [7:0]       count_q, count_d, load_val;
   logic [ScanW-1:0] scan_q, scan_d;
   logic [1:0]       dig_sel_q, dig_sel_d;
   logic [3:0]       tens, ones, digit;
   logic             blank;
   logic [6:0]       seg;

   // Lamp decode and duration of the decoded phase
   always_comb begin
      phase_dec = PhFault;
      case ({bus.red, bus.yellow, bus.green_left, bus.green_straight})
         4'b1000: phase_dec = PhRed;
         4'b0100: phase_dec = PhYellow;
         4'b0010: phase_dec = PhLeft;
         4'b0001: phase_dec = PhStraight;
         default: phase_dec = PhFault;
      endcase

      load_val = 8'd0;
      case (phase_dec)
         PhRed:      load_val = 8'(T_RED);
         PhYellow:   load_val = 8'(T_YELLOW);
         PhLeft:     load_val = 8'(T_LEFT);
         PhStraight: load_val = 8'(T_STRAIGHT);
         default:    load_val = 8'd0;
      endcase
   end

   // Phase register and countdown; a load takes priority over a same-cycle tick
   always_comb begin
      phase_d = phase_q;
      count_d = count_q;
      if (phase_dec != phase_q) begin
         phase_d = phase_dec;
         count_d = load_val;
      end else if (bus.tick && (phase_q != PhFault) && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   // Free-running digit scan, independent of phase and tick
   always_comb begin
      scan_d    = scan_q + ScanW'(1);
      dig_sel_d = dig_sel_q;
      if (scan_q == ScanW'(SCAN_DIV - 1)) begin
         scan_d    = '0;
         dig_sel_d = {dig_sel_q[0], dig_sel_q[1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= PhIdle;
         count_q   <= 8'd0;
         scan_q    <= '0;
         dig_sel_q <= 2'b01;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         scan_q    <= scan_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   // BCD split; durations are capped at 99 so tens stays within 0..9
   always_comb begin
      tens = 4'(count_q / 8'd10);
      ones = 4'(count_q % 8'd10);
   end

   always_comb begin
      digit = dig_sel_q[1] ? tens : ones;
      blank = (phase_q == PhIdle) || (phase_q == PhFault) ||
              (dig_sel_q[1] && (tens == 4'd0));
      seg   = 7'b0000000;
      if (!blank) begin
         case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
         endcase
      end
   end

   assign bus.phase    = phase_q;
   assign bus.count    = count_q;
   assign bus.bcd_tens = tens;
   assign bus.bcd_ones = ones;
   assign bus.seg      = seg;
   assign bus.dig_sel  = dig_sel_q;
   assign bus.fault    = (phase_q == PhFault);

endmodule

// File: tb/tb_traffic_countdown.sv
// tb_traffic_countdown: directed, table-driven bench for traffic_countdown
// with SCAN_DIV = 4 and default phase durations.
module tb_traffic_countdown;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;  // cycles since the last reset edge

   traffic_countdown_if bus_if ();

   traffic_countdown #(
      .T_LEFT    (20),
      .T_STRAIGHT(40),
      .T_YELLOW  (10),
      .T_RED     (70),
      .SCAN_DIV  (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] lamps;  // {red, yellow, green_left, green_straight}
      logic       tick;
      int         exp_phase;
      int         exp_count;
   } vec_t;

   vec_t vq[$];

   function automatic logic [6:0] seg_of(int d);
      case (d)
         0:       return 7'b0111111;
         1:       return 7'b0000110;
         2:       return 7'b1011011;
         3:       return 7'b1001111;
         4:       return 7'b1100110;
         5:       return 7'b1101101;
         6:       return 7'b1111101;
         7:       return 7'b0000111;
         8:       return 7'b1111111;
         9:       return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [1:0] exp_dsel();
      return (((cyc / 4) % 2) == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [6:0] exp_seg(int p, int c);
      if (p == 0 || p == 7) return 7'b0000000;
      if (exp_dsel() == 2'b10) return (c / 10 == 0) ? 7'b0000000 : seg_of(c / 10);
      return seg_of(c % 10);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(string tag, int p, int c);
      chk({tag, ".phase"}, int'(bus_if.phase), p);
      chk({tag, ".count"}, int'(bus_if.count), c);
      chk({tag, ".fault"}, int'(bus_if.fault), (p == 7) ? 1 : 0);
      chk({tag, ".bcd_tens"}, int'(bus_if.bcd_tens), c / 10);
      chk({tag, ".bcd_ones"}, int'(bus_if.bcd_ones), c % 10);
      chk({tag, ".dig_sel"}, int'(bus_if.dig_sel), int'(exp_dsel()));
      chk({tag, ".seg"}, int'(bus_if.seg), int'(exp_seg(p, c)));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_lamps(logic [3:0] l);
      {bus_if.red, bus_if.yellow, bus_if.green_left, bus_if.green_straight} = l;
   endtask

   task automatic add(logic [3:0] l, logic t, int p, int c);
      vec_t v;
      v.lamps     = l;
      v.tick      = t;
      v.exp_phase = p;
      v.exp_count = c;
      vq.push_back(v);
   endtask

   task automatic run_table(string tag);
      for (int i = 0; i < vq.size(); i++) begin
         set_lamps(vq[i].lamps);
         bus_if.tick = vq[i].tick;
         step();
         bus_if.tick = 1'b0;
         check_all($sformatf("%s[%0d]", tag, i), vq[i].exp_phase, vq[i].exp_count);
      end
      vq.delete();
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      repeat (n) step();
      cyc = 0;
   endtask

   initial begin
      rst         = 1'b1;
      bus_if.tick = 1'b0;
      set_lamps(4'b0000);

      // Reset with all lamps low
      do_reset(3);
      check_all("reset", 0, 0);
      rst = 1'b0;

      // Idle -> FAULT, then straight countdown 40..35
      add(4'b0000, 1'b0, 7, 0);
      add(4'b0001, 1'b0, 4, 40);
      for (int i = 1; i <= 5; i++) add(4'b0001, 1'b1, 4, 40 - i);
      run_table("straight");

      // Tens digit of 35 shows a 3
      for (int k = 0; k < 4 && exp_dsel() != 2'b10; k++) step();
      chk("tens35.dig_sel", int'(bus_if.dig_sel), 2);
      chk("tens35.seg", int'(bus_if.seg), int'(7'b1001111));
      chk("tens35.bcd_tens", int'(bus_if.bcd_tens), 3);
      chk("tens35.bcd_ones", int'(bus_if.bcd_ones), 5);

      // Yellow saturation, red load, simultaneous load/tick, fault, glitch
      add(4'b0100, 1'b0, 2, 10);
      for (int i = 1; i <= 12; i++) add(4'b0100, 1'b1, 2, (i < 10) ? 10 - i : 0);
      add(4'b1000, 1'b0, 1, 70);
      add(4'b0001, 1'b0, 4, 40);
      add(4'b0001, 1'b1, 4, 39);
      add(4'b0010, 1'b1, 3, 20);
      add(4'b1010, 1'b0, 7, 0);
      add(4'b1010, 1'b1, 7, 0);
      add(4'b1010, 1'b1, 7, 0);
      add(4'b1000, 1'b0, 1, 70);
      add(4'b1000, 1'b1, 1, 69);
      add(4'b0000, 1'b0, 7, 0);
      add(4'b1000, 1'b0, 1, 70);
      run_table("phases");

      // Reset in the middle of red; first valid pattern after release loads
      do_reset(1);
      check_all("midreset", 0, 0);
      rst = 1'b0;
      add(4'b1000, 1'b0, 1, 70);
      add(4'b0100, 1'b0, 2, 10);
      add(4'b0100, 1'b1, 2, 9);
      add(4'b0100, 1'b1, 2, 8);
      add(4'b0100, 1'b1, 2, 7);
      run_table("postreset");

      // Scan with count 7: tens blank, ones shows 7, dig_sel every 4 cycles
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("scan[%0d]", i), 2, 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_countdown.md
# traffic_countdown

- Downstream display stage for one approach of the 4-way traffic controller.
- Consumes that approach's four lamp outputs and a time-base tick.
- Shows the remaining time of the current phase as a two-digit, multiplexed 7-segment countdown, and flags invalid lamp combinations.
- One instance per approach (N/S/E/W). Phase durations are parameters matching the controller's timing parameters.

## Interface
- T_LEFT, 20, duration of the left-turn green phase, in ticks (1..99)
- T_STRAIGHT, 40, duration of the straight green phase, in ticks (1..99)
- T_YELLOW, 10, duration of the yellow phase, in ticks (1..99)
- T_RED, 70, duration of the red phase, in ticks (1..99)
- SCAN_DIV, 1000, clock cycles per digit in display multiplexing (≥2)
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle strobe. Same time unit the controller uses to count phases.
- red, yellow, green_left, green_straight  in  1 each  lamp outputs of one approach
- phase  out  3  decoded phase: 0 IDLE, 1 RED, 2 YELLOW, 3 LEFT, 4 STRAIGHT, 7 FAULT
- count  out  8  remaining ticks, binary
- bcd_tens, bcd_ones  out  4 each  BCD of count
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dig_sel  out  2  one-hot digit enable: 01 = ones, 10 = tens
- fault  out  1  lamp combination invalid

## Operation
- **Lamp decode (combinational)**
  - Exactly one lamp high selects RED, YELLOW, LEFT or STRAIGHT.
  - Zero lamps, or more than one lamp, decodes to FAULT.
- **Phase change**
  - A phase change is any cycle where the decoded phase differs from the `phase` register. The register updates to the decoded value.
  - On a change into a valid phase, `count` loads that phase's T_* parameter.
  - On a change into FAULT, `count` loads 0.
- **Countdown**
  - On `tick` with no phase change: `count` decrements if greater than 0, and holds at 0 otherwise (no wrap).
  - When a phase change and `tick` occur in the same cycle, the load wins and no decrement happens that cycle.
  - A controller that overruns its phase leaves the display at 0 until the next change.
- **Fault**
  - `fault` equals (`phase` == 7).
  - While in FAULT, `tick` is ignored and the display is blanked.
  - Return to a valid lamp pattern counts as a normal phase change and loads a full duration.
- **BCD (combinational from `count`)**
  - `bcd_tens` = `count` / 10, `bcd_ones` = `count` % 10.
  - Parameters are limited to ≤ 99, so `bcd_tens` never exceeds 9.
- **Display scan**
  - A free-running counter of 0..SCAN_DIV-1 flips `dig_sel` between 01 and 10 on wrap.
  - `seg` shows the selected digit using standard hex-free 0–9 patterns. Examples: 0 = 0111111, 1 = 0000110, 7 = 0000111.
- **Blanking** (`seg` = 0000000) applies when any of these holds:
  - `phase` is IDLE or FAULT;
  - the tens digit is selected and `bcd_tens` == 0 (leading-zero blank);
  - the ones digit is never blanked in a valid phase, so 0 displays as "0".

## Timing
- **Reset values:** `phase` = 0 (IDLE), `count` = 0, `bcd_tens` = `bcd_ones` = 0, `seg` = 0000000, `dig_sel` = 01, scan counter = 0, `fault` = 0.
- **Reset mid-operation:** everything returns to the reset values at the next clock edge. The first valid lamp pattern after release triggers a load.
- **Latency:**
  - Lamp inputs are sampled at edge k. `phase`, `count` and `fault` reflect them after edge k, so they are valid in cycle k+1.
  - `bcd_*` and `seg` follow `count` and `phase` combinationally in the same cycle.
  - `tick` sampled at edge k: the decremented `count` is visible in cycle k+1.
- **Scan timing:** `dig_sel` toggles every SCAN_DIV cycles. The first toggle occurs SCAN_DIV cycles after reset release. Scanning is unaffected by phase, fault or `tick`.
- **Glitch tolerance:** a one-cycle lamp glitch into an invalid pattern produces one cycle of FAULT, followed by a full reload of the phase that resumes. This is intended: the display never shows time from a corrupted phase.

## Test plan
- **Reset/idle**
  - Stimulus: hold `rst` for 3 cycles with all lamps low.
  - Required: all outputs at reset values, then `phase` = 7 and `fault` = 1 one cycle after release.
- **Straight countdown**
  - Stimulus: set green_straight = 1, then apply 5 ticks.
  - Required: `count` reads 40, 39 … 35. `bcd_tens` = 3, `bcd_ones` = 5, and the tens digit shows seg 1001111.
- **Saturation and phase change**
  - Stimulus: set yellow = 1 and apply 12 ticks.
  - Required: `count` reaches 0 after 10 ticks and holds at 0.
  - Stimulus: then switch to red = 1.
  - Required: `count` = 70 and `phase` = 1.
- **Simultaneous events**
  - Stimulus: switch green_straight to green_left in the same cycle as `tick`.
  - Required: `count` = 20, with no decrement.
- **Fault**
  - Stimulus: drive red = 1 and green_left = 1 together, and apply ticks during it.
  - Required: `fault` = 1, `count` = 0, `seg` = 0000000, ticks ignored.
  - Stimulus: release green_left.
  - Required: `fault` = 0 and `count` = 70.
- **Scan and blanking** (SCAN_DIV = 4)
  - Required: `dig_sel` alternates every 4 cycles.
  - With `count` = 7: tens digit blank, ones digit shows seg 0000111.
